// File: rtl/mini_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// mini_cpu_sequencer
//
// Instruction sequencer that sits between the board inputs and the mini CPU.
// It records up to DEPTH 18-bit instructions from the switches and replays
// them into the CPU unattended. For each instruction it presents the word on
// the instruction bus, presses and releases the send button, and then waits
// for the CPU/LCD handshake to finish. When it is not replaying, the switches
// and the button pass straight through to the CPU through one register stage.
//
// Parameters
//   DEPTH   instruction buffer entries (power of two)
//   AW      log2(DEPTH)
//   SETTLE  cycles cpu_instr is held stable before the synthetic press (>=1)
//   TIMEOUT max cycles to wait for cpu_lcd_update after the release
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   sw_in           manual instruction switches
//   man_send        manual send button, active-low
//   rec_push        pulse: append sw_in to the buffer (idle only)
//   run_start       pulse: start replay at entry 0 (idle only)
//   run_stop        pulse: stop once the current instruction completes
//   buf_clear       pulse: empty the buffer and clear the sticky flags (idle only)
//   loop_mode       1 = wrap back to entry 0 after the last entry
//   cpu_lcd_update  CPU's LCD update strobe (instruction accepted)
//   cpu_lcd_busy    LCD controller busy
//   cpu_instr       instruction bus to the CPU switch input
//   cpu_send        send button to the CPU, active-low
//   count           number of valid entries, 0..DEPTH
//   pc              entry being replayed
//   running         replay in progress (any state but IDLE)
//   overflow        sticky: push attempted while the buffer was full
//   timeout_err     sticky: CPU never answered with cpu_lcd_update
// -----------------------------------------------------------------------------
module mini_cpu_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [17:0]   sw_in,
  input  logic          man_send,
  input  logic          rec_push,
  input  logic          run_start,
  input  logic          run_stop,
  input  logic          buf_clear,
  input  logic          loop_mode,
  input  logic          cpu_lcd_update,
  input  logic          cpu_lcd_busy,
  output logic [17:0]   cpu_instr,
  output logic          cpu_send,
  output logic [AW:0]   count,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          overflow,
  output logic          timeout_err
);

  localparam int SCW = $clog2(SETTLE + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]    FULL        = (AW+1)'(DEPTH);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [TW-1:0]  TIMER_MAX   = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_PRESS,
    S_RELEASE,
    S_WAIT_UPD,
    S_WAIT_DONE
  } state_t;

  state_t         state, state_next;
  logic [17:0]    instr_mem [DEPTH];
  logic [AW:0]    count_next;
  logic [AW-1:0]  pc_next;
  logic           overflow_next, timeout_next;
  logic           stop_pending, stop_next;
  logic [SCW-1:0] settle_cnt, settle_next;
  logic [TW-1:0]  timer, timer_next;
  logic [17:0]    instr_next;
  logic           send_next;
  logic           wr_en;
  logic           is_last;

  assign running = (state != S_IDLE);
  assign is_last = ({1'b0, pc} == (count - (AW+1)'(1)));

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_next    = state;
    count_next    = count;
    pc_next       = pc;
    overflow_next = overflow;
    timeout_next  = timeout_err;
    stop_next     = stop_pending;
    settle_next   = settle_cnt;
    timer_next    = timer;
    wr_en         = 1'b0;

    case (state)
      S_IDLE: begin
        // Priority: clear, then start (drops a simultaneous push), then push.
        if (buf_clear) begin
          count_next    = '0;
          overflow_next = 1'b0;
          timeout_next  = 1'b0;
        end else if (run_start) begin
          if ((count != '0) && !cpu_lcd_busy) begin
            pc_next     = '0;
            settle_next = '0;
            state_next  = S_PRESENT;
          end
        end else if (rec_push) begin
          if (count == FULL) begin
            overflow_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            count_next = count + (AW+1)'(1);
          end
        end
      end

      S_PRESENT: begin
        // The counter saturates at SETTLE-1, so a busy LCD simply extends
        // the stable window until it goes idle.
        if (settle_cnt != SETTLE_LAST) begin
          settle_next = settle_cnt + SCW'(1);
        end else if (!cpu_lcd_busy) begin
          state_next = S_PRESS;
        end
      end

      S_PRESS: state_next = S_RELEASE;

      S_RELEASE: begin
        timer_next = '0;
        state_next = S_WAIT_UPD;
      end

      S_WAIT_UPD: begin
        if (cpu_lcd_update) begin
          state_next = S_WAIT_DONE;
        end else if (timer == TIMER_MAX) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!cpu_lcd_busy) begin
          if (stop_pending || run_stop) begin
            state_next = S_IDLE;
          end else if (is_last) begin
            if (loop_mode) begin
              pc_next     = '0;
              settle_next = '0;
              state_next  = S_PRESENT;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            pc_next     = pc + AW'(1);
            settle_next = '0;
            state_next  = S_PRESENT;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase

    if (running && run_stop) stop_next = 1'b1;
    if (state_next == S_IDLE) stop_next = 1'b0;

    // Outputs are registered from the next state so cpu_send is a clean,
    // glitch-free level and the passthrough has a single cycle of latency.
    if (state_next == S_IDLE) begin
      instr_next = sw_in;
      send_next  = man_send;
    end else begin
      instr_next = instr_mem[pc_next];
      send_next  = (state_next != S_PRESS);
    end
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before the edge, independent of statement order.
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      pc           <= '0;
      overflow     <= 1'b0;
      timeout_err  <= 1'b0;
      stop_pending <= 1'b0;
      settle_cnt   <= '0;
      timer        <= '0;
      cpu_instr    <= '0;
      cpu_send     <= 1'b1;
    end else begin
      state        <= state_next;
      count        <= count_next;
      pc           <= pc_next;
      overflow     <= overflow_next;
      timeout_err  <= timeout_next;
      stop_pending <= stop_next;
      settle_cnt   <= settle_next;
      timer        <= timer_next;
      cpu_instr    <= instr_next;
      cpu_send     <= send_next;
    end
  end

  // NOTE: the instruction array has no reset; count alone defines which
  // entries are valid, so stale contents are never read as instructions.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) instr_mem[count[AW-1:0]] <= sw_in;
  end

endmodule

// File: tb/tb_mini_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mini_cpu_sequencer
//
// Self-checking bench for mini_cpu_sequencer. A small behavioural CPU + LCD
// model answers each release of the send button with an LCD update strobe and
// a busy window, executes LOAD/ADDI into a register file, and logs every
// accepted instruction. Expected replay results come from a plain queue of the
// recorded words.
// -----------------------------------------------------------------------------
module tb_mini_cpu_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1023;

  logic          clk = 1'b0;
  logic          rst;
  logic [17:0]   sw_in;
  logic          man_send;
  logic          rec_push;
  logic          run_start;
  logic          run_stop;
  logic          buf_clear;
  logic          loop_mode;
  logic          cpu_lcd_update;
  logic          cpu_lcd_busy;
  logic [17:0]   cpu_instr;
  logic          cpu_send;
  logic [AW:0]   count;
  logic [AW-1:0] pc;
  logic          running;
  logic          overflow;
  logic          timeout_err;

  always #5 clk = ~clk;

  mini_cpu_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .man_send(man_send),
    .rec_push(rec_push), .run_start(run_start), .run_stop(run_stop),
    .buf_clear(buf_clear), .loop_mode(loop_mode),
    .cpu_lcd_update(cpu_lcd_update), .cpu_lcd_busy(cpu_lcd_busy),
    .cpu_instr(cpu_instr), .cpu_send(cpu_send), .count(count), .pc(pc),
    .running(running), .overflow(overflow), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // CPU + LCD model: release of send -> update after upd_lat cycles, with
  // busy asserted for busy_len cycles starting on the update cycle.
  // ---------------------------------------------------------------------------
  bit          respond    = 1'b1;
  bit          busy_force = 1'b0;
  int          upd_lat    = 3;
  int          busy_len   = 4;
  logic        upd_m      = 1'b0;
  int          busy_cnt   = 0;
  int          upd_cnt    = 0;
  int          low_len    = 0;
  logic        prev_send  = 1'b1;
  logic [7:0]  regs [8];
  logic [17:0] instr_log [$];
  int          pc_log    [$];
  int          pulse_w   [$];

  assign cpu_lcd_update = upd_m;
  assign cpu_lcd_busy   = (busy_cnt > 0) || busy_force;

  // Instruction format used by the model: op[17:14] rd[13:11] rs[9:7] imm[6:0]
  task automatic cpu_exec(input logic [17:0] ins);
    case (ins[17:14])
      4'd0: regs[ins[13:11]] = {1'b0, ins[6:0]};
      4'd4: regs[ins[13:11]] = regs[ins[9:7]] + {1'b0, ins[6:0]};
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    #2;
    upd_m = 1'b0;
    if (busy_cnt > 0) busy_cnt--;
    if (upd_cnt > 0) begin
      upd_cnt--;
      if (upd_cnt == 0) begin
        upd_m    = 1'b1;
        busy_cnt = busy_len;
      end
    end
    if (cpu_send === 1'b0) begin
      low_len++;
    end else if (prev_send === 1'b0) begin
      pulse_w.push_back(low_len);
      low_len = 0;
      instr_log.push_back(cpu_instr);
      pc_log.push_back(int'(pc));
      cpu_exec(cpu_instr);
      if (respond) upd_cnt = upd_lat;
    end
    prev_send = cpu_send;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit          watch_en   = 1'b0;
  bit          seen_watch = 1'b0;
  logic [17:0] watch_val  = '0;

  task automatic step();
    @(posedge clk);
    #1;
    if (watch_en && running && (cpu_instr == watch_val)) seen_watch = 1'b1;
  endtask

  task automatic push(input logic [17:0] v);
    sw_in    = v;
    rec_push = 1'b1;
    step();
    rec_push = 1'b0;
  endtask

  task automatic pulse_clear();
    buf_clear = 1'b1;
    step();
    buf_clear = 1'b0;
  endtask

  task automatic pulse_start();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
  endtask

  task automatic idle_settle();
    repeat (20) step();
  endtask

  task automatic clear_logs();
    instr_log.delete();
    pc_log.delete();
    pulse_w.delete();
  endtask

  task automatic wait_idle(input int max, input string name);
    for (int i = 0; i < max && running; i++) step();
    check(name, running, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_instr"}, cpu_instr, 0);
    check({tag, "_send"}, cpu_send, 1);
    check({tag, "_count"}, count, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_timeout"}, timeout_err, 0);
  endtask

  typedef struct {
    logic        push;
    logic        clear;
    logic        run;
    logic        man;
    logic [17:0] sw;
    logic [17:0] e_instr;
    logic        e_send;
    int          e_count;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [17:0] exp_q [$];
    logic        exp_ovf;
    int          n, presses, lows, cycles;
    logic [17:0] v;

    for (int i = 0; i < 8; i++) regs[i] = '0;

    //           push  clr   run   man   sw         e_instr    e_send e_count
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 18'h12345, 18'h12345, 1'b1, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'h3FFFF, 18'h3FFFF, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 18'h00001, 18'h00001, 1'b1, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'h00805, 18'h00805, 1'b1, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 18'h11111, 18'h11111, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'h00805, 18'h00805, 1'b1, 1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'h10883, 18'h10883, 1'b1, 2};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'h2AAAA, 18'h2AAAA, 1'b0, 2};

    // Reset with non-idle inputs so the reset values are distinguishable.
    rst = 1'b1; sw_in = 18'h2BEEF; man_send = 1'b0;
    rec_push = 1'b0; run_start = 1'b0; run_stop = 1'b0;
    buf_clear = 1'b0; loop_mode = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0; man_send = 1'b1;

    // Table: passthrough, ignored start on empty buffer, push, push+clear.
    for (int i = 0; i < 8; i++) begin
      sw_in = vecs[i].sw; man_send = vecs[i].man;
      rec_push = vecs[i].push; buf_clear = vecs[i].clear; run_start = vecs[i].run;
      step();
      rec_push = 1'b0; buf_clear = 1'b0; run_start = 1'b0;
      check($sformatf("vec%0d_instr", i), cpu_instr, vecs[i].e_instr);
      check($sformatf("vec%0d_send", i), cpu_send, vecs[i].e_send);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      check($sformatf("vec%0d_overflow", i), overflow, 0);
      check($sformatf("vec%0d_running", i), running, 0);
    end

    // Two-instruction program: LOAD R1,5 then ADDI R1,R1,3.
    man_send = 1'b1; sw_in = '0;
    idle_settle();
    clear_logs();
    pulse_start();
    check("prog_running", running, 1);
    check("prog_instr0", cpu_instr, 18'h00805);
    check("prog_send_settle0", cpu_send, 1);
    check("prog_pc0", pc, 0);
    for (int i = 0; i < SETTLE - 1; i++) begin
      step();
      check($sformatf("prog_send_settle%0d", i + 1), cpu_send, 1);
    end
    step();
    check("prog_first_press", cpu_send, 0);
    wait_idle(300, "prog_done");
    check("prog_pulses", pulse_w.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("prog_width%0d", i), (i < pulse_w.size()) ? pulse_w[i] : -1, 1);
      check($sformatf("prog_pclog%0d", i), (i < pc_log.size()) ? pc_log[i] : -1, i);
    end
    check("prog_ilog0", (instr_log.size() > 0) ? 32'(instr_log[0]) : 32'hxxxxxxxx, 18'h00805);
    check("prog_ilog1", (instr_log.size() > 1) ? 32'(instr_log[1]) : 32'hxxxxxxxx, 18'h10883);
    check("prog_r1", regs[1], 8);
    check("prog_count_kept", count, 2);
    idle_settle();

    // Overflow on the 17th push, then clear.
    pulse_clear();
    for (int i = 0; i < DEPTH; i++) push(18'($urandom));
    check("ovf_count_full", count, DEPTH);
    check("ovf_flag_pre", overflow, 0);
    push(18'($urandom));
    check("ovf_count_sat", count, DEPTH);
    check("ovf_flag", overflow, 1);
    pulse_clear();
    check("ovf_clear_count", count, 0);
    check("ovf_clear_flag", overflow, 0);
    pulse_start();
    check("start_empty_ignored", running, 0);

    // Loop mode with a stop requested while entry 1 waits for its update.
    push(18'h00A11); push(18'h00B22); push(18'h00C33);
    sw_in = '0; loop_mode = 1'b1;
    idle_settle();
    clear_logs();
    watch_val = 18'h00C33; watch_en = 1'b1; seen_watch = 1'b0;
    pulse_start();
    presses = 0;
    for (int i = 0; i < 300 && presses < 2; i++) begin
      step();
      if (cpu_send === 1'b0) presses++;
    end
    check("stop_presses", presses, 2);
    step();             // RELEASE
    step();             // WAIT_UPD
    run_stop = 1'b1;
    step();
    run_stop = 1'b0;
    wait_idle(300, "stop_idle");
    check("stop_accepted", instr_log.size(), 2);
    check("stop_entry1", (instr_log.size() > 1) ? 32'(instr_log[1]) : 32'hxxxxxxxx, 18'h00B22);
    check("stop_pc1", (pc_log.size() > 1) ? pc_log[1] : -1, 1);
    check("stop_no_entry2", seen_watch, 0);
    watch_en = 1'b0; loop_mode = 1'b0;
    idle_settle();

    // LCD busy during PRESENT holds off the press.
    pulse_clear();
    push(18'h00805);
    sw_in = '0;
    idle_settle();
    pulse_start();
    busy_force = 1'b1;
    lows = 0;
    repeat (10) begin
      step();
      if (cpu_send === 1'b0) lows++;
    end
    check("busy_no_press", lows, 0);
    check("busy_running", running, 1);
    check("busy_instr", cpu_instr, 18'h00805);
    busy_force = 1'b0;
    step();
    check("busy_release_press", cpu_send, 0);
    wait_idle(300, "busy_done");
    idle_settle();

    // Reset while the sequencer is in WAIT_DONE.
    pulse_start();
    for (int i = 0; i < 100 && cpu_lcd_update !== 1'b1; i++) step();
    check("rst_saw_update", cpu_lcd_update, 1);
    check("rst_pre_running", running, 1);
    rst = 1'b1; sw_in = 18'h3FFFF; man_send = 1'b0;
    step();
    rst = 1'b0;
    check_reset_state("rst_mid");
    sw_in = 18'h15A5A; man_send = 1'b0;
    step();
    check("rst_pass_instr", cpu_instr, 18'h15A5A);
    check("rst_pass_send", cpu_send, 0);
    man_send = 1'b1;
    step();
    check("rst_pass_send_hi", cpu_send, 1);
    pulse_start();
    check("rst_buffer_empty", running, 0);
    idle_settle();

    // CPU never answers: timeout.
    respond = 1'b0;
    push(18'h00805);
    sw_in = '0;
    idle_settle();
    pulse_start();
    cycles = 0;
    for (int i = 0; i < TIMEOUT + 60 && running; i++) begin
      step();
      cycles++;
    end
    check("tmo_running", running, 0);
    check("tmo_flag", timeout_err, 1);
    check("tmo_send", cpu_send, 1);
    check("tmo_window", (cycles >= TIMEOUT + SETTLE + 2) && (cycles <= TIMEOUT + SETTLE + 4), 1);
    respond = 1'b1;
    pulse_clear();
    check("tmo_cleared", timeout_err, 0);
    idle_settle();

    // Randomized record/replay rounds against a queue model.
    for (int r = 0; r < 8; r++) begin
      pulse_clear();
      exp_q.delete();
      exp_ovf = 1'b0;
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        v = 18'($urandom);
        push(v);
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        else exp_ovf = 1'b1;
        repeat ($urandom_range(0, 2)) begin
          sw_in = 18'($urandom);
          step();
          check($sformatf("rnd%0d_pass", r), cpu_instr, sw_in);
        end
      end
      check($sformatf("rnd%0d_count", r), count, exp_q.size());
      check($sformatf("rnd%0d_ovf", r), overflow, exp_ovf);
      sw_in = '0;
      idle_settle();
      clear_logs();
      pulse_start();
      wait_idle(2000, $sformatf("rnd%0d_done", r));
      check($sformatf("rnd%0d_nlog", r), instr_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        check($sformatf("rnd%0d_instr%0d", r, k),
              (k < instr_log.size()) ? 32'(instr_log[k]) : 32'hxxxxxxxx, 32'(exp_q[k]));
        check($sformatf("rnd%0d_pc%0d", r, k), (k < pc_log.size()) ? pc_log[k] : -1, k);
        check($sformatf("rnd%0d_width%0d", r, k), (k < pulse_w.size()) ? pulse_w[k] : -1, 1);
      end
      idle_settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mini_cpu_sequencer.md
# mini_cpu_sequencer

Instruction sequencer placed between the board inputs (SW[17:0], KEY[1]) and the mini CPU. It records up to DEPTH 18-bit instructions from the switches and replays them into the CPU unattended. During replay it drives the CPU's instruction bus and synthesises the "send" button release, then waits for the CPU/LCD handshake to finish before issuing the next instruction. When not replaying, it passes the manual switches and button through, so hand operation is unchanged.

## Interface
- DEPTH, 16: instruction buffer entries (power of two).
- AW, 4: log2(DEPTH).
- SETTLE, 2: cycles cpu_instr is held stable before the synthetic press (≥1).
- TIMEOUT, 1023: max cycles to wait for cpu_lcd_update after release.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sw_in  in  18  manual instruction switches.
- man_send  in  1  manual send button, active-low (idle 1).
- rec_push  in  1  one-cycle pulse: append sw_in to buffer.
- run_start  in  1  one-cycle pulse: begin replay at entry 0.
- run_stop  in  1  one-cycle pulse: stop after current instruction.
- buf_clear  in  1  one-cycle pulse: empty buffer, clear flags.
- loop_mode  in  1  1 = wrap to entry 0 after last entry.
- cpu_lcd_update  in  1  CPU's LCD update strobe.
- cpu_lcd_busy  in  1  LCD controller busy.
- cpu_instr  out  18  instruction bus to CPU switches input.
- cpu_send  out  1  send button to CPU, active-low.
- count  out  AW+1  valid entries, 0..DEPTH.
- pc  out  AW  entry being replayed.
- running  out  1  replay in progress.
- overflow  out  1  sticky: push attempted while full.
- timeout_err  out  1  sticky: CPU did not respond.

## Operation
- Buffer: DEPTH×18 register array, write pointer = count. A rec_push in IDLE with count<DEPTH writes sw_in to entry count and increments count. rec_push when full: no write, overflow←1. rec_push while running: ignored, no flag.
- buf_clear (IDLE only): count←0, overflow←0, timeout_err←0. Entries are not zeroed. Ignored while running.
- FSM states: IDLE, PRESENT, PRESS, RELEASE, WAIT_UPD, WAIT_DONE.
- IDLE: cpu_instr←sw_in, cpu_send←man_send (registered passthrough). On run_start with count≠0 and !cpu_lcd_busy: pc←0, running←1, go to PRESENT. run_start with count=0: ignored.
- PRESENT: cpu_instr←buf[pc], cpu_send←1. Hold SETTLE cycles, then go to PRESS, but only if !cpu_lcd_busy; otherwise remain.
- PRESS: cpu_send←0 for exactly 1 cycle, then RELEASE.
- RELEASE: cpu_send←1 (0→1 edge = CPU's release detect), then WAIT_UPD with the timer cleared.
- WAIT_UPD: cpu_instr remains buf[pc]. On cpu_lcd_update go to WAIT_DONE. If the timer reaches TIMEOUT: timeout_err←1, running←0, go to IDLE.
- WAIT_DONE: when !cpu_lcd_busy, advance:
  - If a stop is pending: IDLE.
  - Else if pc==count-1: loop_mode ? pc←0 and PRESENT : IDLE.
  - Else pc←pc+1 and PRESENT.
- run_stop at any running state sets stop_pending. The current instruction always completes its handshake. stop_pending is cleared on entering IDLE. run_start while running: ignored.
- running=1 in every state except IDLE.
- rst mid-replay: immediate IDLE. Buffer contents are retained and count is cleared, so the buffer is logically empty.

## Timing
- Reset values: cpu_instr=0, cpu_send=1, count=0, pc=0, running=0, overflow=0, timeout_err=0, FSM=IDLE.
- Passthrough latency is 1 cycle (sw_in/man_send → cpu_instr/cpu_send).
- run_start to first cpu_send low: 1 (IDLE→PRESENT) + SETTLE cycles.
- cpu_instr is stable from PRESENT entry until WAIT_DONE exit. This covers the CPU's EXECUTE and LATCH reads of the switches.
- Minimum per-instruction period: SETTLE + 4 cycles + CPU response + LCD busy time.
- Simultaneous rec_push and buf_clear in IDLE: buf_clear wins.
- Simultaneous run_start and rec_push in IDLE: run_start wins; the push is dropped.
- Counters saturate: count never exceeds DEPTH; the timer stops at TIMEOUT.

## Test plan
- Record LOAD R1,5 (0x00805), ADDI R1,R1,3 (0x10883), then run with a CPU+LCD model. Required: two send low pulses of 1 cycle each, cpu_instr shows 0x00805 then 0x10883, pc 0→1, running drops after the second WAIT_DONE, and CPU R1=8.
- Push 17 times with DEPTH=16 → count=16, overflow=1. Then buf_clear → count=0, overflow=0.
- loop_mode=1 with 3 entries; assert run_stop while pc=1 is in WAIT_UPD. Required: entry 1 completes, entry 2 is never presented, IDLE is reached.
- CPU model never pulses lcd_update → after TIMEOUT cycles in WAIT_UPD: timeout_err=1, running=0, cpu_send=1.
- Hold cpu_lcd_busy=1 during PRESENT → no send low until busy drops. Also check that run_start with count=0 is ignored.
- rst during WAIT_DONE → next cycle: all outputs at reset values and count=0. In IDLE, man_send/sw_in appear on outputs 1 cycle later.
